irq_ctrl: RTL and testbench

Prioritized interrupt controller between peripheral interrupt sources and the CPU core's single `irq_i` input. Latches rising edges from up to 8 sources, applies a software-programmable mask, picks the highest-priority pending source, and drives the CPU request together with a 16-bit handler vector. Tracks in-service sources until end-of-interrupt, and is configured through a small byte-wide register port on the CPU data bus.

---
 rtl/irq_ctrl_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 17 +
 rtl/irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_irq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the irq_ctrl prioritized interrupt controller.
// State encoding, register map and small bit helpers.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_ISR  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int GIE_BIT = 0;

    function automatic logic [7:0] onehot8(input logic [2:0] id);
        return 8'd1 << id;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// 8-bit priority encoder: reports the lowest set index and whether any bit is set.
// Index 0 wins, matching source 0 being the highest-priority interrupt.
module irq_prio_enc (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) id_o = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritized interrupt controller: edge latch, mask, GIE, request/ack/EOI FSM.
// Define IRQ_CTRL_NESTING_EN to allow a higher-priority source to preempt service.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC    = 8,
    parameter logic [15:0] VEC_BASE = 16'h0008
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_i,
    output logic             irq_o,
    output logic [15:0]      vec_o,
    input  logic             ack_i,
    input  logic             eoi_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [1:0]       addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    localparam logic [7:0] SRC_M = 8'((9'd1 << N_SRC) - 9'd1);

    logic [7:0]  src_w, edge_w, cand_w;
    logic [7:0]  src_q, mask_q, mask_d, pend_q, pend_d;
    logic [7:0]  isr_q, isr_d, rdata_q, rdata_d;
    logic        gie_q, gie_d;
    logic [2:0]  id_q, id_d;
    logic [15:0] vec_q, vec_d;
    state_e      state_q, state_d;

    logic        cand_v, isr_v, take_w, wr_w, rd_w;
    logic [2:0]  cand_id, isr_id;

    assign src_w  = 8'(src_i) & SRC_M;
    assign edge_w = src_w & ~src_q;
    assign cand_w = pend_q & mask_q & {8{gie_q}};
    assign wr_w   = sel_i & we_i;
    assign rd_w   = sel_i & ~we_i;

    irq_prio_enc u_cand_enc (
        .req_i   (cand_w),
        .valid_o (cand_v),
        .id_o    (cand_id)
    );

    irq_prio_enc u_isr_enc (
        .req_i   (isr_q),
        .valid_o (isr_v),
        .id_o    (isr_id)
    );

`ifdef IRQ_CTRL_NESTING_EN
    assign take_w = cand_v & (~isr_v | (cand_id < isr_id));
`else
    assign take_w = cand_v & ~isr_v;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        isr_d   = isr_q;
        gie_d   = gie_q;

        if (wr_w) begin
            unique case (addr_i)
                REG_MASK: mask_d = wdata_i & SRC_M;
                REG_PEND: pend_d = pend_q & ~wdata_i;
                REG_CTRL: gie_d  = wdata_i[GIE_BIT];
                default:  ;
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (take_w) begin
                    state_d = ST_REQ;
                    id_d    = cand_id;
                    vec_d   = VEC_BASE + {11'd0, cand_id, 2'b00};
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    state_d = ST_SERVICE;
                    pend_d  = pend_d & ~onehot8(id_q);
                    isr_d   = isr_q | onehot8(id_q);
                end
            end
            ST_SERVICE: begin
                // EOI has precedence over a same-cycle preemption.
                if (eoi_i) begin
                    isr_d   = isr_q & ~onehot8(isr_id);
                    state_d = (isr_d != 8'h00) ? ST_SERVICE : ST_IDLE;
                end else if (take_w) begin
                    state_d = ST_REQ;
                    id_d    = cand_id;
                    vec_d   = VEC_BASE + {11'd0, cand_id, 2'b00};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d = (pend_d | edge_w) & SRC_M;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_w) begin
            unique case (addr_i)
                REG_MASK: rdata_d = mask_q;
                REG_PEND: rdata_d = pend_q;
                REG_ISR:  rdata_d = isr_q;
                REG_CTRL: rdata_d = {7'd0, gie_q};
                default:  rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= 3'd0;
            vec_q   <= 16'h0000;
            src_q   <= 8'h00;
            mask_q  <= 8'h00;
            pend_q  <= 8'h00;
            isr_q   <= 8'h00;
            gie_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            src_q   <= src_w;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            gie_q   <= gie_d;
            rdata_q <= rdata_d;
        end
    end

    assign irq_o   = (state_q == ST_REQ);
    assign vec_o   = vec_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus randomized traffic
// checked against a register-level behavioural model of the controller.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_NESTING_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src = 8'h00;
    logic        ack = 1'b0, eoi = 1'b0, sel = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [7:0]  wdata = 8'h00;
    logic        irq;
    logic [15:0] vec;
    logic [7:0]  rdata;

    irq_ctrl #(.N_SRC(8), .VEC_BASE(16'h0008)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .src_i   (src),
        .irq_o   (irq),
        .vec_o   (vec),
        .ack_i   (ack),
        .eoi_i   (eoi),
        .sel_i   (sel),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] vec_q[$];
    logic [7:0]  rd_q[$];

    // Model: 0 idle, 1 requesting, 2 in service.
    logic [7:0] m_mask = 0, m_pend = 0, m_isr = 0, m_srcq = 0;
    bit         m_gie = 0, m_irq = 0;
    int         m_st = 0, m_id = 0;
    bit         prev_irq = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic int lowest(logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic [7:0] reg_val(logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return m_isr;
            default: return {7'd0, m_gie};
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] e, cand, np, ni, nm;
        bit ng;
        int c, s, ns;
        if (rst) begin
            m_mask = 0; m_pend = 0; m_isr = 0; m_srcq = 0;
            m_gie = 0; m_st = 0; m_irq = 0;
            return;
        end
        if (sel && !we) rd_q.push_back(reg_val(addr));
        e = src & ~m_srcq;
        cand = m_gie ? (m_pend & m_mask) : 8'h00;
        c = lowest(cand);
        s = lowest(m_isr);
        np = m_pend; ni = m_isr; nm = m_mask; ng = m_gie; ns = m_st;
        if (sel && we) begin
            if (addr == 2'd0) nm = wdata;
            if (addr == 2'd1) np = np & ~wdata;
            if (addr == 2'd3) ng = wdata[0];
        end
        if (m_st == 1 && ack) begin
            np[m_id] = 1'b0;
            ni[m_id] = 1'b1;
            ns = 2;
        end else if (m_st == 2 && eoi) begin
            ni[s] = 1'b0;
            ns = (ni != 0) ? 2 : 0;
        end else if (c < 8 && (m_st == 0 || (NEST && m_st == 2 && c < s))) begin
            ns = 1;
            m_id = c;
            vec_q.push_back(16'h0008 + 16'(4 * c));
        end
        np = np | e;
        m_pend = np; m_isr = ni; m_mask = nm; m_gie = ng; m_st = ns;
        m_srcq = src;
        m_irq = (ns == 1);
    endtask

    task automatic step(bit a, bit e, bit s, bit w, logic [1:0] ad, logic [7:0] d);
        @(negedge clk);
        ack = a; eoi = e; sel = s; we = w; addr = ad; wdata = d;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();                       step(0, 0, 0, 0, 2'd0, 8'h00); endtask
    task automatic wr(logic [1:0] a, logic [7:0] d); step(0, 0, 1, 1, a, d);    endtask
    task automatic rd(logic [1:0] a);            step(0, 0, 1, 0, a, 8'h00);    endtask
    task automatic ackc();                       step(1, 0, 0, 0, 2'd0, 8'h00); endtask
    task automatic eoic();                       step(0, 1, 0, 0, 2'd0, 8'h00); endtask

    always @(posedge clk) begin
        bit rd_now;
        rd_now = sel && !we && !rst;
        #1;
        if (rd_now) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                $display("FAIL rdata_sb: read response with empty queue");
            end else chk("rdata_sb", rdata, rd_q.pop_front());
        end
        chk("irq_level", irq, m_irq);
        if (irq && !prev_irq) begin
            if (vec_q.size() == 0) begin
                n_chk++;
                $display("FAIL vec_sb: unexpected request vec=%0h", vec);
            end else chk("vec_sb", vec, vec_q.pop_front());
        end
        prev_irq = irq;
    end

    initial begin
        rst = 1; src = 0;
        idle(); idle();
        rst = 0;
        chk("rst_irq", irq, 0);
        chk("rst_vec", vec, 16'h0000);
        chk("rst_rdata", rdata, 8'h00);

        wr(2'd0, 8'h04); wr(2'd3, 8'h01);
        src = 8'h04; idle();
        rd(2'd1);
        chk("t1_pend", rdata, 8'h04);
        chk("t1_irq", irq, 1);
        chk("t1_vec", vec, 16'h0010);
        ackc();
        chk("t1_ack_irq", irq, 0);
        rd(2'd2); chk("t1_isr", rdata, 8'h04);
        rd(2'd1); chk("t1_pend_clr", rdata, 8'h00);
        eoic(); src = 0; idle();

        wr(2'd0, 8'hFF);
        src = 8'h22; idle(); idle();
        chk("t2_irq", irq, 1);
        chk("t2_vec", vec, 16'h000C);
        ackc(); eoic(); idle();
        chk("t2_irq2", irq, 1);
        chk("t2_vec2", vec, 16'h001C);
        ackc(); eoic(); src = 0; idle();

        wr(2'd0, 8'h00);
        src = 8'h08; idle();
        rd(2'd1);
        chk("t3_pend", rdata, 8'h08);
        chk("t3_masked", irq, 0);
        wr(2'd0, 8'h08); idle();
        chk("t3_unmask", irq, 1);
        ackc(); eoic();
        src = 0; wr(2'd0, 8'h00);
        src = 8'h08; idle();
        wr(2'd1, 8'h08); wr(2'd0, 8'h08); idle();
        chk("t3_w1c_irq", irq, 0);
        rd(2'd1); chk("t3_w1c_pend", rdata, 8'h00);

        wr(2'd0, 8'hFF);
        src = 8'h0A; idle(); idle();
        chk("t4_vec", vec, 16'h000C);
        wr(2'd3, 8'h00); idle();
        chk("t4_hold", irq, 1);
        ackc();
        chk("t4_ack", irq, 0);
        rd(2'd2); chk("t4_isr", rdata, 8'h02);
        eoic(); wr(2'd3, 8'h01);
        ackc();
        chk("t4_stray_ack", irq, 0);
        rd(2'd2); chk("t4_stray_isr", rdata, 8'h00);
        eoic();
        rd(2'd2); chk("t4_stray_eoi", rdata, 8'h00);
        src = 0; idle();

        src = 8'h10; idle(); idle();
        chk("t5_vec4", vec, 16'h0018);
        ackc();
        src = 8'h11; idle(); idle();
        if (NEST) begin
            chk("t5_nest_irq", irq, 1);
            chk("t5_nest_vec", vec, 16'h0008);
            ackc();
            rd(2'd2); chk("t5_isr2", rdata, 8'h11);
            eoic();
            rd(2'd2); chk("t5_isr1", rdata, 8'h10);
            eoic();
            rd(2'd2); chk("t5_isr0", rdata, 8'h00);
        end else begin
            chk("t5_no_preempt", irq, 0);
            rd(2'd2); chk("t5_isr", rdata, 8'h10);
            eoic(); idle();
            chk("t5_after_eoi", irq, 1);
            chk("t5_vec0", vec, 16'h0008);
            ackc(); eoic();
        end
        src = 0; idle();

        src = 8'h04; idle(); idle();
        chk("t6_req", irq, 1);
        rst = 1; src = 0; idle(); rst = 0;
        chk("t6_irq", irq, 0);
        chk("t6_vec", vec, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk("t6_reg", rdata, 8'h00);
        end

        wr(2'd3, 8'h01); wr(2'd0, 8'hFF);
        for (int k = 0; k < 3000; k++) begin
            bit a, e, s, w;
            logic [1:0] ad;
            logic [7:0] d;
            rst = ($urandom_range(0, 599) == 0);
            src = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            a = (m_st == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            e = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 3) == 0);
            w = 1'($urandom);
            ad = 2'($urandom);
            d = 8'($urandom);
            if (ad == 2'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if (ad == 2'd0) d = d | 8'($urandom);
            step(a, e, s, w, ad, d);
        end
        rst = 0; idle(); idle();

        chk("vec_q_drained", vec_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
